ddr3_rw_arbiter: RTL and testbench

DDR3_RW_ARBITER -- requirements
Module: ddr3_rw_arbiter

---
 rtl/ddr3_rw_arbiter.sv | 154 +++++++++++++++
 tb/tb_ddr3_rw_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_rw_arbiter.sv
// Ping-pong frame-buffer arbiter between a write FIFO, a read FIFO and the MIG user port.
// Writes fill one frame bank while reads replay the last completed frame from the other bank.
module ddr3_rw_arbiter #(
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned FRAME_BEATS = 57600,
  parameter int unsigned ADDR_STEP   = 8,
  parameter int unsigned BANK_BIT    = 24,
  parameter int unsigned RD_LOW      = 256
) (
  input  logic         clk_100,
  input  logic         rst_n,
  input  logic         init_calib_complete,
  input  logic         wr_load,
  input  logic         rd_load,
  input  logic [10:0]  wfifo_rcount,
  input  logic [255:0] wfifo_dout,
  output logic         wfifo_rden,
  input  logic [10:0]  rfifo_wcount,
  output logic [255:0] rfifo_din,
  output logic         rfifo_wren,
  input  logic         app_rdy,
  input  logic         app_wdf_rdy,
  input  logic         app_rd_data_valid,
  input  logic [255:0] app_rd_data,
  output logic         app_en,
  output logic [2:0]   app_cmd,
  output logic [27:0]  app_addr,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  output logic [255:0] app_wdf_data,
  output logic [31:0]  app_wdf_mask
);

  localparam int unsigned CntW = $clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0]     CntOne    = CntW'(1);
  localparam logic [CntW-1:0]     BurstLast = CntW'(BURST_LEN - 1);
  localparam logic [CntW-1:0]     BurstFull = CntW'(BURST_LEN);
  localparam logic [BANK_BIT-1:0] OffLast   = BANK_BIT'((FRAME_BEATS - 1) * ADDR_STEP);
  localparam logic [BANK_BIT-1:0] OffStep   = BANK_BIT'(ADDR_STEP);
  localparam logic [10:0]         WrThresh  = 11'(BURST_LEN);
  localparam logic [10:0]         RdThresh  = 11'(RD_LOW);

  typedef enum logic [1:0] {StInit, StIdle, StWrite, StRead} state_e;

  state_e              state_q;
  logic [CntW-1:0]     wr_cnt_q, rd_cmd_cnt_q, rd_dat_cnt_q;
  logic [BANK_BIT-1:0] wr_off_q, rd_off_q;
  logic                wr_bank_q, rd_bank_q, rd_enable_q;
  logic                wr_load_q, rd_load_q, wr_pend_q, rd_pend_q;
  logic                rfifo_wren_q;
  logic [255:0]        rfifo_din_q;

  logic wr_fire, rd_fire, rd_ok;

  assign wr_fire = (state_q == StWrite) && app_rdy && app_wdf_rdy;
  assign rd_fire = (state_q == StRead) && app_rdy && (rd_cmd_cnt_q != BurstFull);
  // A pending write reload clears rd_enable in this same cycle, so it must also block the read.
  assign rd_ok   = rd_enable_q && !wr_pend_q && (rfifo_wcount < RdThresh);

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state_q      <= StInit;
      wr_cnt_q     <= '0;
      rd_cmd_cnt_q <= '0;
      rd_dat_cnt_q <= '0;
      wr_off_q     <= '0;
      rd_off_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_enable_q  <= 1'b0;
      wr_load_q    <= 1'b0;
      rd_load_q    <= 1'b0;
      wr_pend_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      rfifo_wren_q <= 1'b0;
      rfifo_din_q  <= '0;
    end else begin
      wr_load_q    <= wr_load;
      rd_load_q    <= rd_load;
      rfifo_wren_q <= app_rd_data_valid;
      rfifo_din_q  <= app_rd_data;

      if (wr_fire) begin
        wr_cnt_q <= wr_cnt_q + CntOne;
        if (wr_off_q == OffLast) begin
          // Frame complete: flip banks and let reads follow the frame just written.
          wr_off_q    <= '0;
          wr_bank_q   <= ~wr_bank_q;
          rd_bank_q   <= wr_bank_q;
          rd_enable_q <= 1'b1;
        end else begin
          wr_off_q <= wr_off_q + OffStep;
        end
      end

      if (rd_fire) begin
        rd_cmd_cnt_q <= rd_cmd_cnt_q + CntOne;
        rd_off_q     <= (rd_off_q == OffLast) ? '0 : rd_off_q + OffStep;
      end

      if ((state_q == StRead) && app_rd_data_valid) rd_dat_cnt_q <= rd_dat_cnt_q + CntOne;

      unique case (state_q)
        StInit: if (init_calib_complete) state_q <= StIdle;
        StIdle: begin
          wr_cnt_q     <= '0;
          rd_cmd_cnt_q <= '0;
          rd_dat_cnt_q <= '0;
          if (wr_pend_q) begin
            wr_pend_q   <= 1'b0;
            wr_off_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_enable_q <= 1'b0;
          end
          if (rd_pend_q) begin
            rd_pend_q <= 1'b0;
            rd_off_q  <= '0;
          end
          if (wfifo_rcount >= WrThresh) state_q <= StWrite;
          else if (rd_ok)               state_q <= StRead;
        end
        StWrite: if (wr_fire && (wr_cnt_q == BurstLast)) state_q <= StIdle;
        StRead: if (app_rd_data_valid && (rd_dat_cnt_q == BurstLast)) state_q <= StIdle;
        default: state_q <= StInit;
      endcase

      // Placed after the case so a new edge arriving while a reload is applied is not lost.
      if (wr_load && !wr_load_q) wr_pend_q <= 1'b1;
      if (rd_load && !rd_load_q) rd_pend_q <= 1'b1;
    end
  end

  always_comb begin
    app_en       = wr_fire | rd_fire;
    app_wdf_wren = wr_fire;
    app_wdf_end  = wr_fire;
    wfifo_rden   = wr_fire;
    app_cmd      = (state_q == StRead) ? 3'b001 : 3'b000;
    app_addr     = '0;
    if (state_q == StWrite) begin
      app_addr[BANK_BIT-1:0] = wr_off_q;
      app_addr[BANK_BIT]     = wr_bank_q;
    end else if (state_q == StRead) begin
      app_addr[BANK_BIT-1:0] = rd_off_q;
      app_addr[BANK_BIT]     = rd_bank_q;
    end
  end

  assign app_wdf_data = wfifo_dout;
  assign app_wdf_mask = '0;
  assign rfifo_wren   = rfifo_wren_q;
  assign rfifo_din    = rfifo_din_q;

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Scoreboard bench for ddr3_rw_arbiter: expected MIG addresses are queued as stimulus is
// applied and popped as the DUT issues beats; read-FIFO pushes are checked one cycle after valid.
module tb_ddr3_rw_arbiter;

  localparam int unsigned FrameBeats = 192;  // three bursts per frame keeps the wrap test short

  logic         clk_100 = 1'b0;
  logic         rst_n, init_calib_complete, wr_load, rd_load;
  logic [10:0]  wfifo_rcount, rfifo_wcount;
  logic [255:0] wfifo_dout, rfifo_din, app_rd_data, app_wdf_data;
  logic         wfifo_rden, rfifo_wren, app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic         app_en, app_wdf_wren, app_wdf_end;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;
  logic [31:0]  app_wdf_mask;

  ddr3_rw_arbiter #(
    .BURST_LEN  (64),
    .FRAME_BEATS(FrameBeats),
    .ADDR_STEP  (8),
    .BANK_BIT   (24),
    .RD_LOW     (256)
  ) u_dut (
    .clk_100            (clk_100),
    .rst_n              (rst_n),
    .init_calib_complete(init_calib_complete),
    .wr_load            (wr_load),
    .rd_load            (rd_load),
    .wfifo_rcount       (wfifo_rcount),
    .wfifo_dout         (wfifo_dout),
    .wfifo_rden         (wfifo_rden),
    .rfifo_wcount       (rfifo_wcount),
    .rfifo_din          (rfifo_din),
    .rfifo_wren         (rfifo_wren),
    .app_rdy            (app_rdy),
    .app_wdf_rdy        (app_wdf_rdy),
    .app_rd_data_valid  (app_rd_data_valid),
    .app_rd_data        (app_rd_data),
    .app_en             (app_en),
    .app_cmd            (app_cmd),
    .app_addr           (app_addr),
    .app_wdf_wren       (app_wdf_wren),
    .app_wdf_end        (app_wdf_end),
    .app_wdf_data       (app_wdf_data),
    .app_wdf_mask       (app_wdf_mask)
  );

  always #5 clk_100 = ~clk_100;

  int checks = 0, errors = 0;
  int cyc = 0, pops = 0, rd_cmds = 0, rf_pushes = 0, wlevel = 0;
  logic popped = 1'b0, rf_due = 1'b0;
  logic [255:0] rf_exp = '0;
  logic [27:0] exp_wr_q[$];
  logic [27:0] exp_rd_q[$];
  int span, base, n, first_wr, first_rd;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] mk_addr(input logic bank, input int idx);
    logic [27:0] a;
    a     = 28'(idx * 8);
    a[24] = bank;
    return a;
  endfunction

  task automatic push_wr(input logic bank, input int first_idx);
    for (int i = 0; i < 64; i++) exp_wr_q.push_back(mk_addr(bank, first_idx + i));
  endtask

  task automatic add_words(input int cnt);
    wlevel       = wlevel + cnt;
    wfifo_rcount = 11'(wlevel);
  endtask

  task automatic sample();
    if (app_en && app_cmd == 3'b000) begin
      check_val("wr_strobes", 256'({app_wdf_wren, app_wdf_end, wfifo_rden}), 256'(3'b111));
      check_val("wr_ready", 256'({app_rdy, app_wdf_rdy}), 256'(2'b11));
      check_val("wr_data", app_wdf_data, wfifo_dout);
      check_val("wr_mask", 256'(app_wdf_mask), 256'(0));
      if (exp_wr_q.size() == 0) check_val("wr_extra_beat", 256'(0), 256'(1));
      else                      check_val("wr_addr", 256'(app_addr), 256'(exp_wr_q.pop_front()));
      pops++;
      popped = 1'b1;
    end else begin
      check_val("idle_strobes", 256'({app_wdf_wren, app_wdf_end, wfifo_rden}), 256'(0));
    end
    if (app_en && app_cmd == 3'b001) begin
      check_val("rd_ready", 256'(app_rdy), 256'(1));
      if (exp_rd_q.size() == 0) check_val("rd_extra_cmd", 256'(0), 256'(1));
      else                      check_val("rd_addr", 256'(app_addr), 256'(exp_rd_q.pop_front()));
      rd_cmds++;
    end
    check_val("rf_wren", 256'(rfifo_wren), 256'(rf_due));
    if (rf_due) check_val("rf_din", rfifo_din, rf_exp);
    if (rfifo_wren) rf_pushes++;
    rf_due = app_rd_data_valid;
    rf_exp = app_rd_data;
  endtask

  // Sample at the falling edge, then return just after the next rising edge to drive inputs.
  task automatic tick();
    @(negedge clk_100);
    sample();
    @(posedge clk_100);
    #1;
    cyc++;
    if (popped) begin
      wlevel--;
      popped = 1'b0;
    end
    wfifo_rcount = 11'(wlevel);
    wfifo_dout   = {8{32'(pops)}};
  endtask

  task automatic wait_pops(input string tag, input int target, input int stall_at,
                           input int stall_len, output int span_o);
    int b, first, cnt, st;
    b = pops; first = -1; cnt = 0; st = 0;
    while (pops < target && cnt < 600) begin
      tick();
      cnt++;
      if (first < 0 && pops > b) first = cyc;
      if (st >= 1 && st <= stall_len) begin
        st++;
        if (st > stall_len) app_wdf_rdy = 1'b1;
      end else if (stall_len > 0 && st == 0 && pops == b + stall_at) begin
        app_wdf_rdy = 1'b0;
        st = 1;
      end
    end
    check_val({tag, "_pops"}, 256'(pops), 256'(target));
    span_o = cyc - first;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; init_calib_complete = 1'b0; wr_load = 1'b0; rd_load = 1'b0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0;
    app_rd_data = {8{32'h5a5a_a5a5}};
    rfifo_wcount = 11'd300; wfifo_rcount = '0; wfifo_dout = '0;

    // Reset values
    repeat (3) tick();
    check_val("rst_app_en", 256'(app_en), 256'(0));
    check_val("rst_app_addr", 256'(app_addr), 256'(0));
    check_val("rst_app_cmd", 256'(app_cmd), 256'(0));
    check_val("rst_wfifo_rden", 256'(wfifo_rden), 256'(0));
    check_val("rst_rfifo_wren", 256'(rfifo_wren), 256'(0));
    check_val("rst_rfifo_din", rfifo_din, 256'(0));
    rst_n = 1'b1;
    app_rd_data = '0;

    // Held in INIT until calibration completes
    add_words(64);
    repeat (10) tick();
    check_val("init_hold", 256'(pops), 256'(0));

    // Back-to-back burst, then idle
    push_wr(1'b0, 0);
    init_calib_complete = 1'b1;
    wait_pops("b1", 64, 0, 0, span);
    check_val("b1_span", 256'(span), 256'(63));
    repeat (5) tick();
    check_val("b1_idle", 256'(pops), 256'(64));

    // Write-data stall of 3 cycles after beat 10
    push_wr(1'b0, 64);
    add_words(64);
    wait_pops("b2", 128, 10, 3, span);
    check_val("b2_span", 256'(span), 256'(66));

    // Last burst of the frame wraps the write address
    push_wr(1'b0, 128);
    add_words(64);
    wait_pops("b3", 192, 0, 0, span);
    repeat (3) tick();
    check_val("b3_no_read", 256'(rd_cmds), 256'(0));

    // Write and read both eligible: write first, then read of the completed bank 0 frame
    push_wr(1'b1, 0);
    for (int i = 0; i < 64; i++) exp_rd_q.push_back(mk_addr(1'b0, i));
    add_words(64);
    rfifo_wcount = 11'd0;
    base = pops; first_wr = -1; first_rd = -1; n = 0;
    while (rd_cmds < 64 && n < 600) begin
      tick();
      n++;
      if (first_wr < 0 && pops > base) first_wr = cyc;
      if (first_rd < 0 && rd_cmds > 0) first_rd = cyc;
    end
    check_val("rd_cmds_done", 256'(rd_cmds), 256'(64));
    check_val("wr_before_rd", 256'(first_wr >= 0 && first_wr < first_rd), 256'(1));
    check_val("b4_pops", 256'(pops), 256'(256));

    // Read data arrives late; the arbiter must stay in READ until the 64th beat
    rfifo_wcount = 11'd300;
    push_wr(1'b1, 64);
    add_words(64);
    repeat (20) tick();
    check_val("rd_wait_hold", 256'(pops), 256'(256));
    for (int i = 0; i < 64; i++) begin
      app_rd_data_valid = 1'b1;
      app_rd_data = {8{32'ha000_0000 + 32'(i)}};
      tick();
    end
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    tick();
    check_val("rd_exit_after_last", 256'(pops), 256'(256));
    check_val("rd_no_extra_cmd", 256'(rd_cmds), 256'(64));
    check_val("rf_push_count", 256'(rf_pushes), 256'(64));

    // Write reload mid-burst: burst finishes, then restart at bank 0 offset 0 with reads off
    n = 0;
    while (pops < 276 && n < 200) begin
      tick();
      n++;
    end
    wr_load = 1'b1;
    tick();
    tick();
    wr_load = 1'b0;
    wait_pops("b5", 320, 0, 0, span);
    check_val("b5_queue_empty", 256'(exp_wr_q.size()), 256'(0));
    push_wr(1'b0, 0);
    add_words(64);
    wait_pops("b6", 384, 0, 0, span);
    rfifo_wcount = 11'd0;
    repeat (100) tick();
    check_val("rd_blocked_after_load", 256'(rd_cmds), 256'(64));

    // Reset in the middle of a burst abandons it; the next burst restarts at offset 0
    push_wr(1'b0, 64);
    add_words(64);
    n = 0;
    while (pops < 389 && n < 200) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    tick();
    tick();
    check_val("midrst_app_en", 256'(app_en), 256'(0));
    exp_wr_q.delete();
    rst_n = 1'b1;
    base = pops;
    repeat (20) tick();
    check_val("post_rst_no_write", 256'(pops), 256'(base));
    check_val("post_rst_no_read", 256'(rd_cmds), 256'(64));
    push_wr(1'b0, 0);
    add_words(64);
    wait_pops("b8", base + 64, 0, 0, span);
    check_val("b8_span", 256'(span), 256'(63));
    check_val("b8_queue_empty", 256'(exp_wr_q.size()), 256'(0));
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
